// File: rtl/sat_state_ctrl.sv
// -----------------------------------------------------------------------------
// sat_state_ctrl
//   Control core for the Sat Engine state list. One FSM sequences:
//     - BCP convergence wait (IMPLY), ended by a conflict or by find_imply_i
//       holding steady for IMPLY_STABLE consecutive cycles,
//     - conflict analysis (FIND -> ADD -> DONE), with a FIND timeout,
//     - current-bin backtrack (BKT).
//   Also produces the absolute current level (base + local) and, on entry to
//   DONE, the backtrack level from a NUM_LVLS-wide MSB priority encoder.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   base_lvl_en/_i      load the bin base level (any cycle, any state)
//   local_lvl_i         local decision level; cur_lvl_o = base + local
//   apply_imply_i       start BCP wait          (sampled in IDLE only)
//   find_imply_i        implied-var flags
//   conflict_i          conflict flag from the var states
//   done_imply_o        1-cycle pulse, BCP finished
//   imply_conflict_o    with done_imply_o: BCP ended on a conflict
//   apply_analyze_i     start conflict analysis (sampled in IDLE only)
//   find_conflict_i     learnt-clause membership flags
//   findindex_i         level-state match flags
//   max_lvl_i           max level in the learnt clause
//   add_learntc_en_o    1-cycle pulse, write learnt clause
//   done_analyze_o      1-cycle pulse, analysis finished, bkt_* valid
//   analyze_timeout_o   with done_analyze_o: no learnt clause found
//   bkt_lvl_o           backtrack level (held until next DONE)
//   bkt_inter_bin_o     backtrack leaves the current bin
//   apply_bkt_i         start backtrack         (sampled in IDLE only)
//   done_bkt_o          1-cycle pulse, backtrack done
//   busy_o              FSM not in IDLE
// -----------------------------------------------------------------------------
module sat_state_ctrl #(
  parameter int NUM_VARS        = 8,
  parameter int NUM_LVLS        = 8,
  parameter int WIDTH_LVL       = 16,
  parameter int IMPLY_STABLE    = 1,
  parameter int ANALYZE_TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 base_lvl_en,
  input  logic [WIDTH_LVL-1:0] base_lvl_i,
  input  logic [WIDTH_LVL-1:0] local_lvl_i,
  output logic [WIDTH_LVL-1:0] cur_lvl_o,
  input  logic                 apply_imply_i,
  input  logic [NUM_VARS-1:0]  find_imply_i,
  input  logic                 conflict_i,
  output logic                 done_imply_o,
  output logic                 imply_conflict_o,
  input  logic                 apply_analyze_i,
  input  logic [NUM_VARS-1:0]  find_conflict_i,
  input  logic [NUM_LVLS-1:0]  findindex_i,
  input  logic [WIDTH_LVL-1:0] max_lvl_i,
  output logic                 add_learntc_en_o,
  output logic                 done_analyze_o,
  output logic                 analyze_timeout_o,
  output logic [WIDTH_LVL-1:0] bkt_lvl_o,
  output logic                 bkt_inter_bin_o,
  input  logic                 apply_bkt_i,
  output logic                 done_bkt_o,
  output logic                 busy_o
);

  localparam int SW = $clog2(IMPLY_STABLE + 1);
  localparam int TW = $clog2(ANALYZE_TIMEOUT + 1);
  // Counter value at which the next qualifying cycle completes the window.
  localparam logic [SW-1:0] STB_LAST = SW'(IMPLY_STABLE - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(ANALYZE_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_IMPLY, S_FIND, S_ADD, S_DONE, S_BKT
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH_LVL-1:0] base_q;
  logic [NUM_VARS-1:0]  prev_imply_q;
  logic [NUM_VARS-1:0]  prev_cf_q;
  logic [SW-1:0]        stb_cnt_q;
  logic [TW-1:0]        to_cnt_q;
  logic                 done_imply_q;
  logic                 imply_cf_q;
  logic                 timeout_q;
  logic [WIDTH_LVL-1:0] bkt_lvl_q;
  logic                 bkt_inter_q;

  logic                 imply_same;
  logic                 cf_changed;
  logic                 imply_fin;
  logic                 imply_cf;
  logic                 find_to;
  logic [WIDTH_LVL-1:0] msb_idx;
  logic [WIDTH_LVL-1:0] bkt_lvl_d;

  assign imply_same = (find_imply_i == prev_imply_q);
  assign cf_changed = (find_conflict_i != prev_cf_q);

  // ---------------------------------------------------------------------------
  // Next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    imply_fin = 1'b0;
    imply_cf  = 1'b0;
    find_to   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (apply_bkt_i)          state_d = S_BKT;
        else if (apply_analyze_i) state_d = S_FIND;
        else if (apply_imply_i)   state_d = S_IMPLY;
      end
      S_IMPLY: begin
        // Conflict wins over a window that completes on the same cycle.
        if (conflict_i) begin
          imply_fin = 1'b1;
          imply_cf  = 1'b1;
          state_d   = S_IDLE;
        end else if (imply_same && (stb_cnt_q == STB_LAST)) begin
          imply_fin = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_FIND: begin
        if (cf_changed) begin
          state_d = S_ADD;
        end else if (to_cnt_q == TO_LAST) begin
          find_to = 1'b1;
          state_d = S_DONE;
        end
      end
      S_ADD:   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      S_BKT:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Backtrack level: MSB of findindex_i offset by the base; an empty match
  // means the target is outside this bin, so take the clause's max level.
  // ---------------------------------------------------------------------------
  always_comb begin
    msb_idx = '0;
    for (int i = 0; i < NUM_LVLS; i++) begin
      if (findindex_i[i]) msb_idx = WIDTH_LVL'(i);
    end
  end

  assign bkt_lvl_d = (findindex_i == '0) ? max_lvl_i : (base_q + msb_idx);

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      base_q       <= '0;
      prev_imply_q <= '0;
      prev_cf_q    <= '0;
      stb_cnt_q    <= '0;
      to_cnt_q     <= '0;
      done_imply_q <= 1'b0;
      imply_cf_q   <= 1'b0;
      timeout_q    <= 1'b0;
      bkt_lvl_q    <= '0;
      bkt_inter_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      done_imply_q <= imply_fin;
      imply_cf_q   <= imply_cf;

      if (base_lvl_en) base_q <= base_lvl_i;

      // Stability window: snapshot on entry, then track every cycle.
      if (state_q == S_IDLE && state_d == S_IMPLY) begin
        prev_imply_q <= find_imply_i;
        stb_cnt_q    <= '0;
      end else if (state_q == S_IMPLY) begin
        prev_imply_q <= find_imply_i;
        stb_cnt_q    <= imply_same ? stb_cnt_q + 1'b1 : '0;
      end

      // FIND compares against the entry snapshot; counts unchanged cycles.
      if (state_q == S_IDLE && state_d == S_FIND) begin
        prev_cf_q <= find_conflict_i;
        to_cnt_q  <= '0;
      end else if (state_q == S_FIND && !cf_changed) begin
        to_cnt_q  <= to_cnt_q + 1'b1;
      end

      // DONE is only ever entered from ADD or FIND, never held.
      if (state_d == S_DONE) begin
        timeout_q   <= find_to;
        bkt_lvl_q   <= bkt_lvl_d;
        bkt_inter_q <= (findindex_i == '0);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign cur_lvl_o         = base_q + local_lvl_i;
  assign done_imply_o      = done_imply_q;
  assign imply_conflict_o  = imply_cf_q;
  assign add_learntc_en_o  = (state_q == S_ADD);
  assign done_analyze_o    = (state_q == S_DONE);
  assign analyze_timeout_o = (state_q == S_DONE) && timeout_q;
  assign bkt_lvl_o         = bkt_lvl_q;
  assign bkt_inter_bin_o   = bkt_inter_q;
  assign done_bkt_o        = (state_q == S_BKT);
  assign busy_o            = (state_q != S_IDLE);

endmodule

// File: tb/tb_sat_state_ctrl.sv
// Directed bench for sat_state_ctrl. Two instances share stimulus:
//   u0: IMPLY_STABLE=2, WIDTH_LVL=16, ANALYZE_TIMEOUT=4
//   u1: IMPLY_STABLE=1, WIDTH_LVL=4,  ANALYZE_TIMEOUT=4
// Inputs change 1 ns after a rising edge; outputs are sampled at that point.
module tb_sat_state_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        base_lvl_en;
  logic [15:0] base_lvl_i, local_lvl_i, max_lvl_i;
  logic        apply_imply_i, conflict_i, apply_analyze_i, apply_bkt_i;
  logic [7:0]  find_imply_i, find_conflict_i, findindex_i;

  logic [15:0] cur_lvl, bkt_lvl;
  logic        done_imply, imply_cf, add_en, done_an, an_to, bkt_inter, done_bkt, busy;
  logic [3:0]  u1_cur_lvl, u1_bkt_lvl;
  logic        u1_done_imply, u1_imply_cf, u1_add_en, u1_done_an, u1_an_to;
  logic        u1_bkt_inter, u1_done_bkt, u1_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sat_state_ctrl #(.NUM_VARS(8), .NUM_LVLS(8), .WIDTH_LVL(16),
                   .IMPLY_STABLE(2), .ANALYZE_TIMEOUT(4)) u0 (
    .clk(clk), .rst(rst), .base_lvl_en(base_lvl_en), .base_lvl_i(base_lvl_i),
    .local_lvl_i(local_lvl_i), .cur_lvl_o(cur_lvl), .apply_imply_i(apply_imply_i),
    .find_imply_i(find_imply_i), .conflict_i(conflict_i), .done_imply_o(done_imply),
    .imply_conflict_o(imply_cf), .apply_analyze_i(apply_analyze_i),
    .find_conflict_i(find_conflict_i), .findindex_i(findindex_i), .max_lvl_i(max_lvl_i),
    .add_learntc_en_o(add_en), .done_analyze_o(done_an), .analyze_timeout_o(an_to),
    .bkt_lvl_o(bkt_lvl), .bkt_inter_bin_o(bkt_inter), .apply_bkt_i(apply_bkt_i),
    .done_bkt_o(done_bkt), .busy_o(busy));

  sat_state_ctrl #(.NUM_VARS(8), .NUM_LVLS(8), .WIDTH_LVL(4),
                   .IMPLY_STABLE(1), .ANALYZE_TIMEOUT(4)) u1 (
    .clk(clk), .rst(rst), .base_lvl_en(base_lvl_en), .base_lvl_i(base_lvl_i[3:0]),
    .local_lvl_i(local_lvl_i[3:0]), .cur_lvl_o(u1_cur_lvl), .apply_imply_i(apply_imply_i),
    .find_imply_i(find_imply_i), .conflict_i(conflict_i), .done_imply_o(u1_done_imply),
    .imply_conflict_o(u1_imply_cf), .apply_analyze_i(apply_analyze_i),
    .find_conflict_i(find_conflict_i), .findindex_i(findindex_i), .max_lvl_i(max_lvl_i[3:0]),
    .add_learntc_en_o(u1_add_en), .done_analyze_o(u1_done_an), .analyze_timeout_o(u1_an_to),
    .bkt_lvl_o(u1_bkt_lvl), .bkt_inter_bin_o(u1_bkt_inter), .apply_bkt_i(apply_bkt_i),
    .done_bkt_o(u1_done_bkt), .busy_o(u1_busy));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; base_lvl_en = 1'b0; base_lvl_i = '0; local_lvl_i = '0; max_lvl_i = '0;
    apply_imply_i = 1'b0; conflict_i = 1'b0; apply_analyze_i = 1'b0; apply_bkt_i = 1'b0;
    find_imply_i = '0; find_conflict_i = '0; findindex_i = '0;
    tick(); tick();
    rst = 1'b0;
    tick();

    // Reset state
    chk("rst_busy", busy, 0);
    chk("rst_bkt_lvl", bkt_lvl, 0);
    chk("rst_bkt_inter", bkt_inter, 0);
    chk("rst_cur_lvl", cur_lvl, 0);
    chk("rst_pulses", {done_imply, imply_cf, add_en, done_an, an_to, done_bkt}, 0);

    // 1. u1 IMPLY_STABLE=1, find_imply held 05: done at t+2
    find_imply_i = 8'h05; apply_imply_i = 1'b1;
    tick();                                    // t+1
    apply_imply_i = 1'b0;
    chk("t1_busy_t1", u1_busy, 1);
    chk("t1_done_t1", u1_done_imply, 0);
    tick();                                    // t+2
    chk("t1_done_t2", u1_done_imply, 1);
    chk("t1_cf_t2", u1_imply_cf, 0);
    tick();                                    // t+3: u0 (stable 2) finishes here
    chk("t1_u0_done_t3", done_imply, 1);
    chk("t1_u1_pulse_end", u1_done_imply, 0);
    tick();

    // 2a. u0 IMPLY_STABLE=2, 01 -> 03 at t+1: done at t+4
    find_imply_i = 8'h01; apply_imply_i = 1'b1;
    tick();                                    // t+1
    apply_imply_i = 1'b0; find_imply_i = 8'h03;
    chk("t2a_done_t1", done_imply, 0);
    tick();                                    // t+2
    chk("t2a_done_t2", done_imply, 0);
    tick();                                    // t+3
    chk("t2a_done_t3", done_imply, 0);
    tick();                                    // t+4
    chk("t2a_done_t4", done_imply, 1);
    chk("t2a_cf_t4", imply_cf, 0);
    chk("t2a_busy_t4", busy, 0);
    tick();

    // 2b. conflict at t+2: done + conflict at t+3
    find_imply_i = 8'h01; apply_imply_i = 1'b1;
    tick();                                    // t+1
    apply_imply_i = 1'b0; find_imply_i = 8'h03;
    tick();                                    // t+2
    conflict_i = 1'b1;
    chk("t2b_done_t2", done_imply, 0);
    tick();                                    // t+3
    conflict_i = 1'b0;
    chk("t2b_done_t3", done_imply, 1);
    chk("t2b_cf_t3", imply_cf, 1);
    tick();
    chk("t2b_pulse_end", done_imply, 0);

    // 3. base 10, findindex 0010_0100 -> bkt 15, in-bin
    base_lvl_en = 1'b1; base_lvl_i = 16'd10;
    tick();
    base_lvl_en = 1'b0;
    findindex_i = 8'b0010_0100; max_lvl_i = 16'd3; find_conflict_i = 8'h00;
    apply_analyze_i = 1'b1;
    tick();                                    // t+1
    apply_analyze_i = 1'b0; find_conflict_i = 8'h11;
    chk("t3_busy_t1", busy, 1);
    chk("t3_add_t1", add_en, 0);
    tick();                                    // t+2
    chk("t3_add_t2", add_en, 1);
    chk("t3_done_t2", done_an, 0);
    tick();                                    // t+3
    chk("t3_done_t3", done_an, 1);
    chk("t3_timeout", an_to, 0);
    chk("t3_add_t3", add_en, 0);
    chk("t3_bkt_lvl", bkt_lvl, 15);
    chk("t3_bkt_inter", bkt_inter, 0);
    chk("t3_u1_bkt_lvl", u1_bkt_lvl, 15);
    tick();
    chk("t3_done_end", done_an, 0);
    chk("t3_bkt_hold", bkt_lvl, 15);

    // 4. findindex 0, max 7, find_conflict constant, timeout 4 -> done at t+5
    findindex_i = 8'h00; max_lvl_i = 16'd7; apply_analyze_i = 1'b1;
    tick();                                    // t+1
    apply_analyze_i = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      chk("t4_add_wait", add_en, 0);
      chk("t4_done_wait", done_an, 0);
      if (c < 4) tick();
    end
    tick();                                    // t+5
    chk("t4_done", done_an, 1);
    chk("t4_timeout", an_to, 1);
    chk("t4_add", add_en, 0);
    chk("t4_bkt_lvl", bkt_lvl, 7);
    chk("t4_bkt_inter", bkt_inter, 1);
    tick();
    chk("t4_timeout_end", an_to, 0);

    // 5. all requests together -> only backtrack
    apply_bkt_i = 1'b1; apply_analyze_i = 1'b1; apply_imply_i = 1'b1;
    tick();                                    // t+1
    apply_bkt_i = 1'b0; apply_analyze_i = 1'b0; apply_imply_i = 1'b0;
    chk("t5_done_bkt_t1", done_bkt, 1);
    chk("t5_busy_t1", busy, 1);
    tick();                                    // t+2
    chk("t5_done_bkt_t2", done_bkt, 0);
    chk("t5_busy_t2", busy, 0);
    chk("t5_no_imply", done_imply, 0);
    chk("t5_no_add", add_en, 0);
    // requests while busy are dropped
    apply_analyze_i = 1'b1;
    tick();                                    // FIND, t+1
    apply_analyze_i = 1'b0; apply_bkt_i = 1'b1; apply_imply_i = 1'b1;
    for (int c = 2; c <= 4; c++) begin
      tick();
      chk("t5_busy_drop", done_bkt, 0);
    end
    apply_bkt_i = 1'b0; apply_imply_i = 1'b0;
    tick();                                    // t+5
    chk("t5_an_done", done_an, 1);
    chk("t5_an_to", an_to, 1);
    tick();
    chk("t5_idle_bkt", done_bkt, 0);
    chk("t5_idle_busy", busy, 0);
    tick();
    chk("t5_idle_imply", done_imply, 0);

    // 6. reset mid-FIND aborts silently
    apply_analyze_i = 1'b1;
    tick();
    apply_analyze_i = 1'b0;
    tick();
    chk("t6_busy_find", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_busy_rst", busy, 0);
    chk("t6_bkt_rst", bkt_lvl, 0);
    chk("t6_inter_rst", bkt_inter, 0);
    for (int c = 0; c < 6; c++) begin
      chk("t6_no_pulse", {add_en, done_an, an_to, done_bkt, done_imply}, 0);
      tick();
    end
    chk("t6_busy_after", busy, 0);
    // 4-bit wrap: 15 + 2 = 1
    base_lvl_en = 1'b1; base_lvl_i = 16'd15; local_lvl_i = 16'd2;
    tick();
    base_lvl_en = 1'b0;
    chk("t6_u1_cur_wrap", u1_cur_lvl, 1);
    chk("t6_u0_cur", cur_lvl, 17);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
